gemm_result_writer: RTL and testbench

- Sink for the serialized requantized int8 stream of the GEMM block, driven by its GEMM_valid_o / GEMM_out[7:0] pair.
- Packs consecutive bytes into SRAM-width words with a byte mask, buffers them in a small word FIFO, and writes them to output SRAM through a valid/ready write port at consecutive word addresses.
- A run is framed by a start pulse carrying the expected result count; done_o pulses when every byte has been committed to SRAM.

---
 rtl/gemm_result_writer.sv | 205 ++++++++++++++++++++
 tb/tb_gemm_result_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_writer.sv
`default_nettype none
// ============================================================================
// gemm_result_writer: packs the serialized int8 GEMM result stream into
// masked SRAM words, buffers them in a word FIFO and writes them out.
// Revision: 1.0
// ============================================================================
module gemm_result_writer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SRAM_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 13,
  parameter int COUNT_WIDTH = 18,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init,
  input  logic                              start,
  input  logic [COUNT_WIDTH-1:0]            total_count,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic                              data_valid_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  output logic                              sram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]             sram_addr_o,
  output logic [SRAM_WIDTH-1:0]             sram_wdata_o,
  output logic [SRAM_WIDTH/DATA_WIDTH-1:0]  sram_wmask_o,
  input  logic                              sram_ready_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [COUNT_WIDTH-1:0]            words_written_o,
  output logic                              overflow_o
);

  localparam int LANES  = SRAM_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [SRAM_WIDTH-1:0]  pack_q, pack_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d;
  logic                   ovf_q, ovf_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  logic [SRAM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [LANES-1:0]       fifo_mask_q [FIFO_DEPTH];

  logic                   w_clear;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  logic [SRAM_WIDTH-1:0]  w_word_data;
  logic [LANES-1:0]       w_word_mask;
  logic [COUNT_WIDTH-1:0] w_byte_inc;

  assign w_clear    = rst | init;
  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign w_byte_inc = byte_cnt_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    byte_cnt_d = byte_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    w_push_req = 1'b0;
    w_pop      = !w_empty && sram_ready_i;

    w_word_data = pack_q;
    w_word_data[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = data_i;
    w_word_mask = mask_q;
    w_word_mask[lane_q] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d    = total_count;
          addr_d     = base_addr;
          words_d    = '0;
          ovf_d      = 1'b0;
          byte_cnt_d = '0;
          lane_d     = '0;
          pack_d     = '0;
          mask_d     = '0;
          state_d    = (total_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (data_valid_i) begin
          pack_d     = w_word_data;
          mask_d     = w_word_mask;
          lane_d     = lane_q + LANE_W'(1);
          byte_cnt_d = w_byte_inc;
          if ((lane_q == LANE_W'(LANES-1)) || (w_byte_inc == total_q)) begin
            w_push_req = 1'b1;
            pack_d     = '0;
            mask_d     = '0;
            lane_d     = '0;
          end
          if (w_byte_inc == total_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (w_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    w_push = w_push_req && (!w_full || w_pop);

    if ((w_push_req && !w_push) || (data_valid_i && state_q != S_COLLECT)) begin
      ovf_d = 1'b1;
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_WIDTH'(1);
      words_d  = words_q + COUNT_WIDTH'(1);
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      byte_cnt_q <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      byte_cnt_q <= byte_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= w_word_data;
      fifo_mask_q[wr_ptr_q] <= w_word_mask;
    end
  end

  assign sram_wr_en_o    = !w_empty;
  assign sram_addr_o     = addr_q;
  assign sram_wdata_o    = w_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign sram_wmask_o    = w_empty ? '0 : fifo_mask_q[rd_ptr_q];
  assign busy_o          = (state_q == S_COLLECT) || (state_q == S_FLUSH);
  assign done_o          = (state_q == S_DONE);
  assign words_written_o = words_q;
  assign overflow_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_result_writer.sv
`default_nettype none
// ============================================================================
// tb_gemm_result_writer: directed self-checking bench for gemm_result_writer.
// Revision: 1.0
// ============================================================================
module tb_gemm_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic [17:0] total_count = '0;
  logic [12:0] base_addr = '0;
  logic        data_valid_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        sram_wr_en_o;
  logic [12:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_wmask_o;
  logic        sram_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [17:0] words_written_o;
  logic        overflow_o;

  gemm_result_writer dut (
    .clk             (clk),
    .rst             (rst),
    .init            (init),
    .start           (start),
    .total_count     (total_count),
    .base_addr       (base_addr),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .sram_wr_en_o    (sram_wr_en_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wdata_o    (sram_wdata_o),
    .sram_wmask_o    (sram_wmask_o),
    .sram_ready_i    (sram_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .words_written_o (words_written_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_n = 0;
  int          done_n = 0;
  int          busy_n = 0;
  int          wren_n = 0;
  logic [12:0] log_addr [64];
  logic [63:0] log_data [64];
  logic [7:0]  log_mask [64];

  // Accepted writes and pulse counts, observed mid-cycle.
  always @(negedge clk) begin
    if (sram_wr_en_o && sram_ready_i) begin
      log_addr[wr_n % 64] = sram_addr_o;
      log_data[wr_n % 64] = sram_wdata_o;
      log_mask[wr_n % 64] = sram_wmask_o;
      wr_n = wr_n + 1;
    end
    if (done_o)       done_n = done_n + 1;
    if (busy_o)       busy_n = busy_n + 1;
    if (sram_wr_en_o) wren_n = wren_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [17:0] cnt, input logic [12:0] base);
    start = 1'b1;
    total_count = cnt;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      data_valid_i = 1'b1;
      data_i = first + 8'(i);
      tick();
    end
    data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int d0 = done_n;
    int k = 0;
    while (done_n == d0 && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 64'(done_n - d0), 64'd1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [12:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    chk({tag, "_addr"}, 64'(log_addr[idx % 64]), 64'(a));
    chk({tag, "_data"}, log_data[idx % 64], d);
    chk({tag, "_mask"}, 64'(log_mask[idx % 64]), 64'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    int b0;
    int e0;
    logic [63:0] exp_w;

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_wr_en", 64'(sram_wr_en_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_words", 64'(words_written_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_addr", 64'(sram_addr_o), 64'd0);

    // Two full words at 0x010 with back-to-back bytes.
    w0 = wr_n;
    d0 = done_n;
    do_start(18'd16, 13'h010);
    chk("t1_busy", 64'(busy_o), 64'd1);
    send(7, 8'h00);
    chk("t1_no_wr_yet", 64'(sram_wr_en_o), 64'd0);
    send(1, 8'h07);
    chk("t1_latency", 64'(sram_wr_en_o), 64'd1);
    send(8, 8'h08);
    wait_done("t1_done", 50);
    chk("t1_nwr", 64'(wr_n - w0), 64'd2);
    chk_wr("t1_w0", w0, 13'h010, 64'h0706050403020100, 8'hFF);
    chk_wr("t1_w1", w0 + 1, 13'h011, 64'h0F0E0D0C0B0A0908, 8'hFF);
    chk("t1_words", 64'(words_written_o), 64'd2);
    chk("t1_ovf", 64'(overflow_o), 64'd0);
    chk("t1_busy_end", 64'(busy_o), 64'd0);
    tick();
    tick();
    chk("t1_done_once", 64'(done_n - d0), 64'd1);

    // Partial final word: 11 bytes.
    w0 = wr_n;
    do_start(18'd11, 13'h020);
    send(11, 8'h80);
    wait_done("t2_done", 50);
    chk("t2_nwr", 64'(wr_n - w0), 64'd2);
    chk_wr("t2_w0", w0, 13'h020, 64'h8786858483828180, 8'hFF);
    chk_wr("t2_w1", w0 + 1, 13'h021, 64'h00000000008A8988, 8'h07);
    chk("t2_words", 64'(words_written_o), 64'd2);

    // Zero-length run.
    b0 = busy_n;
    e0 = wren_n;
    do_start(18'd0, 13'h030);
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_busy", 64'(busy_o), 64'd0);
    tick();
    chk("t3_done_end", 64'(done_o), 64'd0);
    chk("t3_busy_cnt", 64'(busy_n - b0), 64'd0);
    chk("t3_wren_cnt", 64'(wren_n - e0), 64'd0);
    chk("t3_words", 64'(words_written_o), 64'd0);

    // 48 bytes into a stalled port: two words overflow the FIFO.
    sram_ready_i = 1'b0;
    w0 = wr_n;
    d0 = done_n;
    do_start(18'd48, 13'h100);
    send(48, 8'h00);
    chk("t4_ovf", 64'(overflow_o), 64'd1);
    chk("t4_wr_en", 64'(sram_wr_en_o), 64'd1);
    chk("t4_held_addr", 64'(sram_addr_o), 64'h100);
    chk("t4_held_data", sram_wdata_o, 64'h0706050403020100);
    chk("t4_no_accept", 64'(wr_n - w0), 64'd0);
    repeat (11) tick();
    sram_ready_i = 1'b1;
    wait_done("t4_done", 100);
    chk("t4_nwr", 64'(wr_n - w0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 8; b++) exp_w[8*b +: 8] = 8'(8*i + b);
      chk_wr("t4_w", w0 + i, 13'h100 + 13'(i), exp_w, 8'hFF);
    end
    chk("t4_words", 64'(words_written_o), 64'd4);
    chk("t4_ovf_end", 64'(overflow_o), 64'd1);
    tick();
    chk("t4_done_once", 64'(done_n - d0), 64'd1);

    // Stray byte in IDLE, then start clears the flag.
    w0 = wr_n;
    data_valid_i = 1'b1;
    data_i = 8'h55;
    tick();
    data_valid_i = 1'b0;
    chk("t5_ovf", 64'(overflow_o), 64'd1);
    chk("t5_no_wr", 64'(sram_wr_en_o), 64'd0);
    do_start(18'd8, 13'h040);
    chk("t5_ovf_clr", 64'(overflow_o), 64'd0);
    send(8, 8'hA0);
    wait_done("t5_done", 50);
    chk("t5_nwr", 64'(wr_n - w0), 64'd1);
    chk_wr("t5_w0", w0, 13'h040, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
    chk("t5_ovf_end", 64'(overflow_o), 64'd0);

    // Soft init mid-run with a stalled write.
    sram_ready_i = 1'b0;
    d0 = done_n;
    do_start(18'd16, 13'h050);
    send(13, 8'h00);
    chk("t6_pending", 64'(sram_wr_en_o), 64'd1);
    w0 = wr_n;
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("t6_wr_en", 64'(sram_wr_en_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_words", 64'(words_written_o), 64'd0);
    chk("t6_addr", 64'(sram_addr_o), 64'd0);
    chk("t6_wmask", 64'(sram_wmask_o), 64'd0);
    sram_ready_i = 1'b1;
    repeat (5) tick();
    chk("t6_no_done", 64'(done_n - d0), 64'd0);
    chk("t6_no_wr", 64'(wr_n - w0), 64'd0);

    // Fresh run after init, wrapping the address space.
    do_start(18'd16, 13'h1FFF);
    send(16, 8'h10);
    wait_done("t7_done", 50);
    chk("t7_nwr", 64'(wr_n - w0), 64'd2);
    chk_wr("t7_w0", w0, 13'h1FFF, 64'h1716151413121110, 8'hFF);
    chk_wr("t7_w1", w0 + 1, 13'h0000, 64'h1F1E1D1C1B1A1918, 8'hFF);
    chk("t7_words", 64'(words_written_o), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
